// File: rtl/dig_ramp_pkg.sv
// Shared types and defaults for the ramp conversion sequencer.
// States, default geometry and small state-decode helpers.
package dig_ramp_pkg;

    localparam int CNT_W_DEF      = 8;
    localparam int DIS_CYCLES_DEF = 4;
    localparam int TMR_W          = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        RAMP      = 2'd2,
        DONE      = 2'd3
    } ramp_state_t;

    function automatic logic state_busy(input ramp_state_t s);
        return (s != IDLE);
    endfunction

    // The capacitor is released only while the ramp is running.
    function automatic logic state_discharge(input ramp_state_t s);
        return (s != RAMP);
    endfunction

    function automatic logic state_valid(input ramp_state_t s);
        return (s == DONE);
    endfunction

endpackage

// File: rtl/dig_cmp_sync.sv
// Two-flop synchronizer for the asynchronous ramp comparator output.
// Used by dig_ramp_seq only when DIG_CMP_SYNC_EN is defined.
module dig_cmp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    // Two-stage metastability filter, both stages clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/dig_ramp_seq.sv
// Ramp ADC conversion sequencer: discharge timing, ramp count capture, valid/ready result.
// Optional comparator synchronizer selected by the DIG_CMP_SYNC_EN macro.
module dig_ramp_seq
    import dig_ramp_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DIS_CYCLES = DIS_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp,
    output logic             discharge,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             valid,
    input  logic             ready
);

    localparam logic [TMR_W-1:0] DIS_LAST = TMR_W'(DIS_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_INC  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_INC  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    ramp_state_t      state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             discharge_q;
    logic             busy_q;
    logic             valid_q;
    logic             cmp_s;

`ifdef DIG_CMP_SYNC_EN
    dig_cmp_sync u_cmp_sync (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (cmp),
        .q_o   (cmp_s)
    );
`else
    assign cmp_s = cmp;
`endif

    // Next-state, timer, counter and capture logic.
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DISCHARGE;
                    tmr_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DISCHARGE: begin
                tmr_d = tmr_q + TMR_INC;
                if (tmr_q == DIS_LAST) begin
                    state_d = RAMP;
                    cnt_d   = '0;
                end else begin
                    state_d = DISCHARGE;
                end
            end
            RAMP: begin
                if (cmp_s) begin
                    result_d = cnt_q;
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_MAX) begin
                    // Full scale without a trip: saturate rather than wrap.
                    result_d = CNT_MAX;
                    ovf_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_INC;
                    state_d = RAMP;
                end
            end
            DONE: begin
                if (ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            discharge_q <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            discharge_q <= state_discharge(state_d);
            busy_q      <= state_busy(state_d);
            valid_q     <= state_valid(state_d);
        end
    end

    assign discharge = discharge_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_dig_ramp_seq.sv
// Self-checking bench for dig_ramp_seq (default build, comparator unsynchronized).
// Table vectors, hand-written reset/abort sequences and randomized conversions against a reference model.
module tb_dig_ramp_seq;

    localparam int DIS  = 4;
    localparam int FULL = 255;

    logic       clk;
    logic       reset;
    logic       start;
    logic       cmp;
    logic       ready;
    logic       discharge;
    logic       busy;
    logic [7:0] result;
    logic       overflow;
    logic       valid;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int k;
        int rw;
        bit sr;
        int exp_res;
        int exp_ovf;
        int exp_lat;
    } vec_t;

    vec_t vecs[8];

    dig_ramp_seq #(.CNT_W(8), .DIS_CYCLES(DIS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cmp       (cmp),
        .discharge (discharge),
        .busy      (busy),
        .result    (result),
        .overflow  (overflow),
        .valid     (valid),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the comparator is seen at ramp count k; the count saturates at full scale.
    function automatic void model(input int k, output int res, output int ovf, output int lat);
        if (k > FULL) begin
            res = FULL;
            ovf = 1;
        end else begin
            res = k;
            ovf = 0;
        end
        lat = DIS + 2 + res;
    endfunction

    // One conversion: cmp rises k cycles into the ramp, result accepted after rw wait cycles.
    task automatic run_conv(input int k, input int rw, input bit sr, input bit noise,
                            input int exp_res, input int exp_ovf, input int exp_lat, input string tag);
        int c;
        int lowcnt;
        bit seen;
        start = 1'b1;
        cmp   = 1'b0;
        ready = 1'b0;
        tick();
        start  = 1'b0;
        c      = 1;
        lowcnt = 0;
        seen   = 1'b0;
        check({tag, " busy_at_1"}, busy, 1);
        for (int i = 0; i < 400; i++) begin
            if (c == DIS + 1 + k) cmp = 1'b1;
            if (noise) start = 1'($urandom_range(0, 1));
            if (valid) begin
                seen = 1'b1;
                break;
            end
            if (!discharge) lowcnt++;
            tick();
            c++;
        end
        check({tag, " valid_seen"}, seen, 1);
        check({tag, " latency"}, c, exp_lat);
        check({tag, " ramp_cycles"}, lowcnt, exp_res + 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " overflow"}, overflow, exp_ovf);
        check({tag, " discharge_done"}, discharge, 1);
        for (int i = 0; i < rw; i++) begin
            if (noise) start = 1'($urandom_range(0, 1));
            tick();
            check({tag, " valid_hold"}, valid, 1);
            check({tag, " result_hold"}, result, exp_res);
        end
        ready = 1'b1;
        start = sr;
        tick();
        ready = 1'b0;
        start = 1'b0;
        cmp   = 1'b0;
        check({tag, " valid_drop"}, valid, 0);
        check({tag, " idle_after"}, busy, 0);
        check({tag, " result_keep"}, result, exp_res);
        tick();
        check({tag, " no_restart"}, busy, 0);
    endtask

    initial begin
        int r;
        int o;
        int l;
        int k;
        reset = 1'b0;
        start = 1'b0;
        cmp   = 1'b0;
        ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            start = 1'($urandom_range(0, 1));
            cmp   = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            #10;
            check("rst discharge", discharge, 1);
            check("rst valid", valid, 0);
            check("rst busy", busy, 0);
            check("rst result", result, 0);
            check("rst overflow", overflow, 0);
        end
        start = 1'b0;
        cmp   = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst busy", busy, 0);
        check("post_rst discharge", discharge, 1);
        check("post_rst valid", valid, 0);

        vecs[0] = '{k: 37,  rw: 3,  sr: 1'b0, exp_res: 37,  exp_ovf: 0, exp_lat: 43};
        vecs[1] = '{k: 0,   rw: 0,  sr: 1'b0, exp_res: 0,   exp_ovf: 0, exp_lat: 6};
        vecs[2] = '{k: 1,   rw: 1,  sr: 1'b0, exp_res: 1,   exp_ovf: 0, exp_lat: 7};
        vecs[3] = '{k: 254, rw: 0,  sr: 1'b0, exp_res: 254, exp_ovf: 0, exp_lat: 260};
        vecs[4] = '{k: 255, rw: 0,  sr: 1'b0, exp_res: 255, exp_ovf: 0, exp_lat: 261};
        vecs[5] = '{k: 256, rw: 2,  sr: 1'b0, exp_res: 255, exp_ovf: 1, exp_lat: 261};
        vecs[6] = '{k: 300, rw: 0,  sr: 1'b0, exp_res: 255, exp_ovf: 1, exp_lat: 261};
        vecs[7] = '{k: 10,  rw: 10, sr: 1'b1, exp_res: 10,  exp_ovf: 0, exp_lat: 16};

        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].k, vecs[i].rw, vecs[i].sr, 1'b0,
                     vecs[i].exp_res, vecs[i].exp_ovf, vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Abort mid-ramp at count 100, then a fresh conversion.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DIS + 100; i++) tick();
        check("abort in_ramp", discharge, 0);
        #2;
        reset = 1'b0;
        #1;
        check("abort discharge_async", discharge, 1);
        check("abort valid", valid, 0);
        check("abort busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("abort idle", busy, 0);
        run_conv(20, 1, 1'b0, 1'b0, 20, 0, DIS + 2 + 20, "after_abort");

        // Randomized conversions against the model, with start noise while busy.
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 300);
            model(k, r, o, l);
            run_conv(k, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b1, r, o, l,
                     $sformatf("rand%0d_k%0d", i, k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dig_ramp_seq.md
# dig_ramp_seq

Conversion sequencer for the analog ramp front end. It owns the capacitor `discharge` control and the 8-bit ramp counter. On `start` it holds the capacitor discharged for a fixed time, then releases it. It counts clock cycles until the ramp comparator trips and presents the captured count to the consumer with a valid/ready handshake.

## Interface
- `CNT_W`, 8: ramp counter and result width.
- `DIS_CYCLES`, 4: minimum discharge duration in clock cycles; legal range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `start`  in  1  conversion request; sampled only in IDLE.
- `cmp`  in  1  comparator output from the analog ramp; 1 = threshold crossed; asynchronous to `clk`.
- `discharge`  out  1  1 = capacitor switch closed (discharged).
- `busy`  out  1  1 in any state except IDLE.
- `result`  out  CNT_W  captured ramp count; stable while `valid`=1.
- `overflow`  out  1  ramp reached full scale without a comparator trip; qualified by `valid`.
- `valid`  out  1  result available.
- `ready`  in  1  consumer accepts the result.

## Operation
States: IDLE, DISCHARGE, RAMP, DONE. All transitions are on the `clk` rising edge.

- Reset (`reset`=0, asynchronous) forces:
  - state = IDLE
  - `discharge`=1, `busy`=0, `valid`=0, `overflow`=0
  - `result`=0
  - internal counters = 0
- IDLE: `discharge`=1. If `start`=1, go to DISCHARGE and clear the discharge timer.
- DISCHARGE: `discharge`=1.
  - The timer increments each cycle.
  - After exactly DIS_CYCLES cycles in this state, go to RAMP with ramp counter = 0.
- RAMP: `discharge`=0. Each cycle:
  - If `cmp_s`=1: `result` ← counter, `overflow` ← 0, go to DONE.
  - Else if counter = 2^CNT_W−1: `result` ← 2^CNT_W−1, `overflow` ← 1, go to DONE.
  - Else counter ← counter+1.
- DONE: `discharge`=1, `valid`=1.
  - When `ready`=1, go to IDLE; `valid` drops the next cycle.
  - `result` and `overflow` hold until the next capture.
- `start` outside IDLE is ignored. Requests are not queued.
- `start` and `ready` both high in DONE: the handshake completes and `start` is ignored. A new request must be presented in IDLE.
- `cmp` already 1 at RAMP entry: result = 0 without the synchronizer; result = 0 or 1 with it, per pipeline fill.
- Counter arithmetic is unsigned CNT_W bits and never wraps. The overflow path stops it at full scale.
- Reset asserted mid-RAMP aborts the conversion and closes `discharge` immediately, asynchronously.

## Timing
- `start` in IDLE at cycle 0 gives:
  - `discharge` low from cycle 1+DIS_CYCLES.
  - `busy` high from cycle 1.
- Capture latency: `valid` rises 1 cycle after the RAMP cycle where `cmp_s`=1.
- `cmp_s` lags `cmp` by 2 cycles when synchronized, 0 cycles otherwise.
- Minimum conversion, start to `valid`: DIS_CYCLES+2 cycles without the synchronizer.
- Maximum conversion, start to `valid` (overflow case): DIS_CYCLES+2^CNT_W+1 cycles.
- `ready` is only observed while `valid`=1. Back-to-back conversions need one IDLE cycle between them.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `DIG_CMP_SYNC_EN` defined: `cmp` passes through a 2-flop synchronizer (reset value 0) before the FSM, so `cmp_s` is `cmp` delayed 2 cycles. Captured counts are 2 higher than the unsynchronized build for the same analog crossing.
- Not defined: `cmp_s` = `cmp` directly, for benches and for a front end that already registers the comparator.

## Structure
- Package `dig_ramp_pkg`:
  - state enum `ramp_state_t` (IDLE, DISCHARGE, RAMP, DONE)
  - default constants `CNT_W_DEF`=8 and `DIS_CYCLES_DEF`=4
- Sub-module `dig_cmp_sync`: 2-flop synchronizer with asynchronous active-low reset. Instantiated only under `DIG_CMP_SYNC_EN`.
- Top level contains the FSM, discharge timer, ramp counter and output registers.

## Test plan
- Reset: hold `reset`=0 with random inputs → `discharge`=1, `valid`=0, `busy`=0, `result`=0. Release → remains IDLE.
- Nominal, no sync, DIS_CYCLES=4: `start` at cycle 0, `cmp` rises in RAMP counter cycle 37 → `result`=37, `overflow`=0, `valid` held until `ready`, `discharge` low only during RAMP.
- Overflow: `start`, `cmp` held 0 → `result`=255, `overflow`=1, `valid` at cycle 4+256+1 after `start`.
- Handshake: `ready`=0 for 10 cycles in DONE, then `ready`=1 together with `start`=1 → `result` stable throughout, IDLE next cycle, no new conversion started.
- Abort: assert `reset` mid-RAMP at counter 100 → `discharge`=1 asynchronously, no `valid`. Next `start` yields a fresh count from 0.
- `DIG_CMP_SYNC_EN` build: same stimulus as the nominal case → `result`=39.
